// File: rtl/nec_prefetch_pkg.sv
// Shared prefetch types: queue depth seen by nec_decode, FSM states and the
// segment:offset to physical address mapping used for word fetches.
package nec_prefetch_pkg;

  localparam int IPQ_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } prefetch_state_e;

  // Even word address inside the segment, wrapped to the 20-bit bus.
  function automatic logic [19:0] phys_word_addr(input logic [15:0] seg,
                                                 input logic [15:0] off);
    return {seg, 4'h0} + {4'h0, off[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/nec_prefetch.sv
// Instruction prefetch unit: fills an 8-byte, address-indexed circular queue
// from 16-bit bus fetches and exposes it to nec_decode as ipq/ipq_len.
module nec_prefetch
  import nec_prefetch_pkg::*;
#(
  parameter int QUEUE_BYTES = IPQ_BYTES
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        ce_1,
  input  logic                        ce_2,
  input  logic [15:0]                 ps,
  input  logic [15:0]                 decode_pc,
  input  logic                        set_pc,
  input  logic [15:0]                 new_pc,
  input  logic                        fetch_inhibit,
  output logic                        fetch_req,
  output logic [19:0]                 fetch_addr,
  input  logic                        fetch_ack,
  input  logic [15:0]                 fetch_data,
  output logic [QUEUE_BYTES-1:0][7:0] ipq,
  output logic [3:0]                  ipq_len
);

  prefetch_state_e r_state, w_state_nxt;
  logic [15:0]                 r_fetch_pc, w_fetch_pc_nxt;
  logic [19:0]                 r_fetch_addr;
  logic [QUEUE_BYTES-1:0][7:0] r_ipq;

  logic                        w_ce, w_flush, w_ack, w_fill, w_issue;
  logic [3:0]                  w_ipq_len;
  logic [2:0]                  w_idx, w_idx_hi;
  logic [QUEUE_BYTES-1:0]      w_byte_we;
  logic [QUEUE_BYTES-1:0][7:0] w_byte_wd;

  assign w_ce      = ce_1 | ce_2;
  assign w_flush   = w_ce & set_pc;
  assign w_ipq_len = r_fetch_pc[3:0] - decode_pc[3:0];
  assign w_ack     = ce_2 & fetch_ack & (r_state != IDLE);
  // A flush coinciding with the ack wins, so that word never reaches the queue.
  assign w_fill    = w_ack & (r_state == REQ) & ~set_pc;
  assign w_issue   = ce_1 & (r_state == IDLE) & ~fetch_inhibit & ~set_pc &
                     (w_ipq_len <= 4'd6);
  assign w_idx     = r_fetch_pc[2:0];
  assign w_idx_hi  = w_idx + 3'd1;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_issue) w_state_nxt = REQ;
      REQ:     if (w_ack) w_state_nxt = IDLE;
               else if (w_flush) w_state_nxt = DISCARD;
      DISCARD: if (w_ack) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    w_byte_we      = '0;
    w_byte_wd      = '0;
    if (w_flush) begin
      w_fetch_pc_nxt = new_pc;
    end else if (w_fill) begin
      if (r_fetch_pc[0]) begin
        // Odd offset: only the high byte of the word belongs to the stream.
        w_byte_we[w_idx] = 1'b1;
        w_byte_wd[w_idx] = fetch_data[15:8];
        w_fetch_pc_nxt   = r_fetch_pc + 16'd1;
      end else begin
        w_byte_we[w_idx]    = 1'b1;
        w_byte_wd[w_idx]    = fetch_data[7:0];
        w_byte_we[w_idx_hi] = 1'b1;
        w_byte_wd[w_idx_hi] = fetch_data[15:8];
        w_fetch_pc_nxt      = r_fetch_pc + 16'd2;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_fetch_pc   <= '0;
      r_fetch_addr <= '0;
    end else if (w_ce) begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      if (w_issue) r_fetch_addr <= phys_word_addr(ps, r_fetch_pc);
    end
  end

  // NOTE: the queue array is reset on purpose so decode never sees X bytes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ipq <= '0;
    end else if (w_ce) begin
      for (int i = 0; i < QUEUE_BYTES; i++) begin
        if (w_byte_we[i]) r_ipq[i] <= w_byte_wd[i];
      end
    end
  end

  assign fetch_req  = (r_state != IDLE);
  assign fetch_addr = r_fetch_addr;
  assign ipq        = r_ipq;
  assign ipq_len    = w_ipq_len;

endmodule

// File: tb/tb_nec_prefetch.sv
// Self-checking bench for nec_prefetch: directed scenarios plus a randomized
// phase, compared against a transaction-level queue model.
module tb_nec_prefetch;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             ce_1, ce_2;
  logic [15:0]      ps, decode_pc, new_pc, fetch_data;
  logic             set_pc, fetch_inhibit, fetch_ack;
  logic             fetch_req;
  logic [19:0]      fetch_addr;
  logic [7:0][7:0]  ipq;
  logic [3:0]       ipq_len;

  int tests  = 0;
  int failed = 0;
  bit phase  = 1'b0;

  // Reference model: stream offset of the next byte, queue bytes by address
  // mod 8, and the bus transaction in flight.
  logic [15:0] m_pc;
  logic [7:0]  m_q [8];
  bit          m_busy, m_discard;
  logic [19:0] m_addr;

  nec_prefetch dut (
    .clk(clk), .reset_n(reset_n), .ce_1(ce_1), .ce_2(ce_2), .ps(ps),
    .decode_pc(decode_pc), .set_pc(set_pc), .new_pc(new_pc),
    .fetch_inhibit(fetch_inhibit), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .ipq(ipq), .ipq_len(ipq_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int model_len();
    return (int'(m_pc) - int'(decode_pc)) & 15;
  endfunction

  task automatic model_reset();
    m_pc = '0; m_busy = 0; m_discard = 0; m_addr = '0;
    for (int i = 0; i < 8; i++) m_q[i] = '0;
  endtask

  // Applies the edge about to happen to the model, from the current inputs.
  task automatic model_step();
    bit ce, ack;
    int off;
    ce  = ce_1 || ce_2;
    ack = ce_2 && fetch_ack && m_busy;
    if (ack && !m_discard && !set_pc) begin
      off = int'(m_pc);
      if (off % 2 == 1) begin
        m_q[off % 8] = fetch_data[15:8];
        m_pc = 16'((off + 1) % 65536);
      end else begin
        m_q[off % 8]       = fetch_data[7:0];
        m_q[(off + 1) % 8] = fetch_data[15:8];
        m_pc = 16'((off + 2) % 65536);
      end
    end
    if (ce && set_pc) m_pc = new_pc;
    if (ack) begin
      m_busy = 0; m_discard = 0;
    end else if (m_busy && ce && set_pc) begin
      m_discard = 1;
    end else if (!m_busy && ce_1 && !fetch_inhibit && !set_pc && model_len() <= 6) begin
      m_busy = 1;
      m_addr = 20'((int'(ps) * 16 + int'(m_pc) - int'(m_pc) % 2) % (1 << 20));
    end
  endtask

  task automatic check_all();
    check("fetch_req", 32'(fetch_req), 32'(m_busy));
    check("fetch_addr", 32'(fetch_addr), 32'(m_addr));
    check("ipq_len", 32'(ipq_len), 32'(model_len()));
    for (int i = 0; i < 8; i++)
      check($sformatf("ipq[%0d]", i), 32'(ipq[i]), 32'(m_q[i]));
  endtask

  task automatic tick();
    ce_1 = (phase == 1'b0);
    ce_2 = (phase == 1'b1);
    model_step();
    @(posedge clk);
    #1;
    phase = ~phase;
    check_all();
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!fetch_req && n < 40) begin
      tick();
      n++;
    end
    check({tag, " req timeout"}, 32'(fetch_req), 32'd1);
  endtask

  task automatic ack_now(input logic [15:0] d);
    if (phase == 1'b0) tick();
    fetch_ack  = 1'b1;
    fetch_data = d;
    tick();
    fetch_ack  = 1'b0;
  endtask

  task automatic redirect(input logic [15:0] pc);
    set_pc = 1'b1; new_pc = pc; decode_pc = pc;
    tick();
    set_pc = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ce_1 = 0; ce_2 = 0; ps = '0; decode_pc = '0; new_pc = '0;
    set_pc = 0; fetch_inhibit = 0; fetch_ack = 0; fetch_data = '0;
    model_reset();
    #12;
    check_all();
    reset_n = 1'b1;
    @(posedge clk); #1;

    // First fetch after redirect, then fill the queue with decode stalled.
    ps = 16'h1000;
    redirect(16'h0100);
    wait_req("first");
    check("first addr", 32'(fetch_addr), 32'h10100);
    ack_now(16'hBBAA);
    check("ipq0 AA", 32'(ipq[0]), 32'hAA);
    check("ipq1 BB", 32'(ipq[1]), 32'hBB);
    check("len 2", 32'(ipq_len), 32'd2);
    repeat (3) begin
      wait_req("fill");
      ack_now(16'($urandom));
    end
    check("full len", 32'(ipq_len), 32'd8);
    repeat (10) tick();
    check("full no req", 32'(fetch_req), 32'd0);
    decode_pc = 16'h0102;
    wait_req("resume");
    ack_now(16'($urandom));
    repeat (10) tick();
    check("one req only", 32'(fetch_req), 32'd0);
    check("refull len", 32'(ipq_len), 32'd8);

    // Odd redirect stores only the high byte.
    redirect(16'h0103);
    wait_req("odd");
    check("odd addr", 32'(fetch_addr), 32'h10102);
    ack_now(16'h2211);
    check("ipq3 22", 32'(ipq[3]), 32'h22);
    check("odd len", 32'(ipq_len), 32'd1);
    wait_req("after odd");
    check("after odd addr", 32'(fetch_addr), 32'h10104);

    // Redirect with a request outstanding: held, then discarded.
    redirect(16'h0200);
    check("discard req held", 32'(fetch_req), 32'd1);
    check("discard addr held", 32'(fetch_addr), 32'h10104);
    ack_now(16'($urandom));
    check("discard len", 32'(ipq_len), 32'd0);
    wait_req("post discard");
    check("post discard addr", 32'(fetch_addr), 32'h10200);

    // Redirect coinciding with the ack.
    if (phase == 1'b0) tick();
    set_pc = 1; new_pc = 16'h0300; decode_pc = 16'h0300;
    fetch_ack = 1; fetch_data = 16'($urandom);
    tick();
    set_pc = 0; fetch_ack = 0;
    check("coincide req", 32'(fetch_req), 32'd0);
    check("coincide len", 32'(ipq_len), 32'd0);

    // Segment and physical wrap-around.
    fetch_inhibit = 1;
    tick(); tick();
    if (fetch_req) ack_now(16'($urandom));
    ps = 16'hF000;
    redirect(16'hFFFE);
    fetch_inhibit = 0;
    wait_req("wrap");
    check("wrap addr", 32'(fetch_addr), 32'hFFFFE);
    ack_now(16'h5A4B);
    check("wrap len", 32'(ipq_len), 32'd2);
    check("wrap ipq6", 32'(ipq[6]), 32'h4B);
    check("wrap ipq7", 32'(ipq[7]), 32'h5A);
    wait_req("wrapped");
    check("wrapped addr", 32'(fetch_addr), 32'hF0000);

    // Inhibit blocks new requests but lets the outstanding one finish.
    fetch_inhibit = 1;
    ack_now(16'hD00D);
    check("inhibit fill len", 32'(ipq_len), 32'd4);
    repeat (10) tick();
    check("inhibit no req", 32'(fetch_req), 32'd0);
    fetch_inhibit = 0;

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      fetch_inhibit = ($urandom_range(0, 7) == 0);
      fetch_ack     = 1'($urandom_range(0, 1));
      fetch_data    = 16'($urandom);
      set_pc        = ($urandom_range(0, 19) == 0);
      if (set_pc) begin
        new_pc    = 16'($urandom);
        decode_pc = new_pc;
        ps        = 16'($urandom);
      end else begin
        decode_pc = 16'(int'(decode_pc) + int'($urandom_range(0, model_len())));
      end
      tick();
    end
    set_pc = 0; fetch_ack = 0; fetch_inhibit = 0;

    // Reset during a request drops fetch_req immediately.
    decode_pc = m_pc;
    wait_req("pre reset");
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("reset req", 32'(fetch_req), 32'd0);
    check_all();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
